// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Default bus widths, register-file size and source identifiers used by
// the arbiter and its FIFOs; helper for the destination range check.
package wb_pkg;

  localparam int BIT_NUMBER_DEF      = 64;
  localparam int ADDR_NUMBER_DEF     = 5;
  localparam int REGISTER_NUMBER_DEF = 16;

  // Round-robin pointer values: which source wins the next contested grant.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned nregs);
    return addr < nregs;
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry result buffer in front of the writeback arbiter.
// Latency: a pushed entry is visible at head_dat the cycle after the push edge.
// Backpressure: full is a registered count==2; push while full is ignored.
// Ports: clk/reset (sync, active-high); push/push_dat write; pop consumes
//        head_dat; full/empty/count report the registered occupancy.
module wb_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             do_push;
  logic             do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry 0 is always the head. A simultaneous push/pop can only happen at
  // count==1 (push is blocked when full), so the new entry becomes the head.
  always_ff @(posedge clk) begin
    if (do_push && do_pop) begin
      mem[0] <= push_dat;
    end else if (do_pop) begin
      mem[0] <= mem[1];
    end else if (do_push) begin
      mem[count[0]] <= push_dat;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU results into one registered register-file write port.
// Latency: 2 edges from accept to wb_we (FIFO edge, then output register edge).
// Backpressure: x_ready = source FIFO not full (registered), forced 0 in reset.
// Ports: alu_*/lsu_* valid-ready result inputs; wb_we/wb_addr/wb_data
//        registered write port; err_oob sticky out-of-range flag;
//        fwd_* bypass of the entry being popped, only when WB_BYPASS_EN is
//        defined (otherwise tied to 0).
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int BIT_NUMBER      = BIT_NUMBER_DEF,
  parameter int ADDR_NUMBER     = ADDR_NUMBER_DEF,
  parameter int REGISTER_NUMBER = REGISTER_NUMBER_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_NUMBER-1:0] alu_addr,
  input  logic [BIT_NUMBER-1:0]  alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [ADDR_NUMBER-1:0] lsu_addr,
  input  logic [BIT_NUMBER-1:0]  lsu_data,
  output logic                   wb_we,
  output logic [ADDR_NUMBER-1:0] wb_addr,
  output logic [BIT_NUMBER-1:0]  wb_data,
  output logic                   err_oob,
  output logic                   fwd_valid,
  output logic [ADDR_NUMBER-1:0] fwd_addr,
  output logic [BIT_NUMBER-1:0]  fwd_data
);

  typedef struct packed {
    logic [ADDR_NUMBER-1:0] addr;
    logic [BIT_NUMBER-1:0]  data;
  } entry_t;

  entry_t     alu_in, lsu_in, alu_head, lsu_head, pop_entry;
  logic       alu_full, lsu_full, alu_empty, lsu_empty;
  logic [1:0] alu_count, lsu_count;
  logic       pop_alu, pop_lsu, pop_any, pop_in_range, contested;
  logic       rr_ptr;
  logic       unused_fifo_count;

  assign alu_in    = '{addr: alu_addr, data: alu_data};
  assign lsu_in    = '{addr: lsu_addr, data: lsu_data};
  assign alu_ready = ~alu_full & ~reset;
  assign lsu_ready = ~lsu_full & ~reset;
  assign unused_fifo_count = ^{alu_count, lsu_count};

  wb_skid_fifo #(.WIDTH($bits(entry_t))) u_alu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (alu_valid & alu_ready),
    .push_dat (alu_in),
    .pop      (pop_alu),
    .head_dat (alu_head),
    .full     (alu_full),
    .empty    (alu_empty),
    .count    (alu_count)
  );

  wb_skid_fifo #(.WIDTH($bits(entry_t))) u_lsu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (lsu_valid & lsu_ready),
    .push_dat (lsu_in),
    .pop      (pop_lsu),
    .head_dat (lsu_head),
    .full     (lsu_full),
    .empty    (lsu_empty),
    .count    (lsu_count)
  );

  // The pointer only decides contested cycles; a lone requester is served
  // without disturbing whose turn it is next.
  assign contested = ~alu_empty & ~lsu_empty;

  always_comb begin
    pop_alu = 1'b0;
    pop_lsu = 1'b0;
    if (contested) begin
      pop_alu = (rr_ptr == SRC_ALU);
      pop_lsu = (rr_ptr == SRC_LSU);
    end else if (!alu_empty) begin
      pop_alu = 1'b1;
    end else if (!lsu_empty) begin
      pop_lsu = 1'b1;
    end
  end

  assign pop_any      = pop_alu | pop_lsu;
  assign pop_entry    = pop_lsu ? lsu_head : alu_head;
  assign pop_in_range = pop_any &
                        addr_in_range(32'(pop_entry.addr), REGISTER_NUMBER);

  // Out-of-range entries are drained but leave wb_addr/wb_data untouched,
  // so those always reflect the last real write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      err_oob <= 1'b0;
      rr_ptr  <= SRC_ALU;
    end else begin
      wb_we <= pop_in_range;
      if (pop_in_range) begin
        wb_addr <= pop_entry.addr;
        wb_data <= pop_entry.data;
      end
      if (pop_any && !pop_in_range) begin
        err_oob <= 1'b1;
      end
      if (contested) begin
        rr_ptr <= ~rr_ptr;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid = pop_in_range;
  assign fwd_addr  = pop_in_range ? pop_entry.addr : '0;
  assign fwd_data  = pop_in_range ? pop_entry.data : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based model plus directed scenarios.
module tb_writeback_arbiter;

  localparam int NREG = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_addr = '0, lsu_addr = '0;
  logic [63:0] alu_data = '0, lsu_data = '0;
  logic        wb_we, err_oob, fwd_valid;
  logic [4:0]  wb_addr, fwd_addr;
  logic [63:0] wb_data, fwd_data;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .err_oob(err_oob),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] addr; logic [63:0] data; } item_t;
  typedef struct { logic [4:0] addr; logic [63:0] data; int cyc; } wr_t;

  item_t aq[$], bq[$];   // stimulus waiting to be offered
  item_t ma[$], mb[$];   // model: what each source buffer holds
  wr_t   wlog[$];        // writes seen on the DUT port

  int total = 0, bad = 0, cyc = 0;
  bit live = 0;
  logic        m_we = 0, m_err = 0;
  logic [4:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  int rr = 0;            // 0: ALU wins next contested cycle
  bit acc_a, acc_b, contend;
  int g;
  item_t e, h;
  int lsu_acc_cnt, refusal_at;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pick();
    if (ma.size() > 0 && mb.size() > 0) return rr;
    if (ma.size() > 0) return 0;
    if (mb.size() > 0) return 1;
    return -1;
  endfunction

  // Model: state after each edge, from the input values just before it.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      ma.delete(); mb.delete();
      m_we = 0; m_addr = '0; m_data = '0; m_err = 0; rr = 0; live = 1;
    end else begin
      acc_a = alu_valid && (ma.size() < 2);
      acc_b = lsu_valid && (mb.size() < 2);
      contend = (ma.size() > 0) && (mb.size() > 0);
      g = pick();
      m_we = 0;
      if (g >= 0) begin
        if (g == 0) e = ma.pop_front(); else e = mb.pop_front();
        if (contend) rr = 1 - rr;
        if (e.addr < NREG) begin
          m_we = 1; m_addr = e.addr; m_data = e.data;
        end else begin
          m_err = 1;
        end
      end
      if (acc_a) ma.push_back('{alu_addr, alu_data});
      if (acc_b) mb.push_back('{lsu_addr, lsu_data});
    end
  end

  // Compare on the falling edge, away from any output change.
  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("wb_we", wb_we, m_we);
      if (m_we) begin
        chk("wb_addr", wb_addr, m_addr);
        chk("wb_data", wb_data, m_data);
      end
      chk("err_oob", err_oob, m_err);
      chk("alu_ready", alu_ready, !reset && ma.size() < 2);
      chk("lsu_ready", lsu_ready, !reset && mb.size() < 2);
`ifdef WB_BYPASS_EN
      g = pick();
      if (g >= 0) h = (g == 0) ? ma[0] : mb[0];
      if (g >= 0 && h.addr < NREG) begin
        chk("fwd_valid", fwd_valid, 1);
        chk("fwd_addr", fwd_addr, h.addr);
        chk("fwd_data", fwd_data, h.data);
      end else begin
        chk("fwd_valid", fwd_valid, 0);
      end
`else
      chk("fwd_off", {fwd_valid, fwd_addr, fwd_data}, 0);
`endif
      if (wb_we) wlog.push_back('{wb_addr, wb_data, cyc});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers queued items, holding each until its handshake completes.
  task automatic drive(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bit a_acc, b_acc;
      alu_valid = aq.size() > 0;
      if (alu_valid) begin alu_addr = aq[0].addr; alu_data = aq[0].data; end
      lsu_valid = bq.size() > 0;
      if (lsu_valid) begin lsu_addr = bq[0].addr; lsu_data = bq[0].data; end
      @(negedge clk);
      a_acc = alu_valid && alu_ready;
      b_acc = lsu_valid && lsu_ready;
      if (lsu_valid && !lsu_ready && refusal_at < 0) refusal_at = lsu_acc_cnt;
      if (b_acc) lsu_acc_cnt++;
      @(posedge clk); #1;
      if (a_acc) aq.delete(0);
      if (b_acc) bq.delete(0);
    end
    alu_valid = 0; lsu_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle(2); reset = 0;
    wlog.delete();
  endtask

  initial begin
    int na, nb;
    // Reset state
    @(posedge clk); #3;
    chk("rst_we", wb_we, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_err", err_oob, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    @(posedge clk); #1; reset = 0;
    #2 chk("post_rst_ready", alu_ready, 1);
    @(posedge clk); #1;

    // Single ALU write: accepted at E1, visible after E2 for one cycle
    alu_valid = 1; alu_addr = 5'd3; alu_data = 64'hAA;
    @(posedge clk); #1; alu_valid = 0;
    #2 chk("single_we_early", wb_we, 0);
`ifdef WB_BYPASS_EN
    chk("single_fwd_valid", fwd_valid, 1);
    chk("single_fwd_addr", fwd_addr, 3);
`endif
    @(posedge clk); #3;
    chk("single_we", wb_we, 1);
    chk("single_addr", wb_addr, 3);
    chk("single_data", wb_data, 64'hAA);
    @(posedge clk); #3;
    chk("single_we_drop", wb_we, 0);
    chk("single_addr_hold", wb_addr, 3);
    @(posedge clk); #1;

    // Contention: both sources stream, writes must alternate ALU/LSU
    do_reset();
    for (int i = 0; i < 6; i++) begin
      aq.push_back('{5'd1, 64'h100 + i});
      bq.push_back('{5'd2, 64'h200 + i});
    end
    drive(16); idle(3);
    chk("cont_count", wlog.size(), 12);
    for (int i = 0; i < 12 && i < wlog.size(); i++) begin
      chk("cont_addr", wlog[i].addr, (i % 2 == 0) ? 1 : 2);
      chk("cont_data", wlog[i].data, ((i % 2 == 0) ? 64'h100 : 64'h200) + i / 2);
    end
    if (wlog.size() >= 12) chk("cont_back2back", wlog[11].cyc - wlog[0].cyc, 11);

    // Backpressure: LSU gets 4 items against a saturating ALU
    do_reset();
    lsu_acc_cnt = 0; refusal_at = -1;
    for (int i = 0; i < 8; i++) aq.push_back('{5'd1, 64'h400 + i});
    for (int i = 0; i < 4; i++) bq.push_back('{5'd2, 64'h300 + i});
    drive(20); idle(3);
    chk("bp_accepts_before_stall", refusal_at, 2);
    na = 0; nb = 0;
    foreach (wlog[i]) begin
      if (wlog[i].addr == 1) begin chk("bp_alu_order", wlog[i].data, 64'h400 + na); na++; end
      else begin chk("bp_lsu_order", wlog[i].data, 64'h300 + nb); nb++; end
    end
    chk("bp_alu_count", na, 8);
    chk("bp_lsu_count", nb, 4);

    // Out-of-range destination is dropped and latches err_oob
    do_reset();
    aq.push_back('{5'd20, 64'h55});
    aq.push_back('{5'd4, 64'h66});
    drive(4); idle(2);
    chk("oob_writes", wlog.size(), 1);
    if (wlog.size() > 0) chk("oob_survivor", wlog[0].addr, 4);
    #2 chk("oob_err", err_oob, 1);
    idle(4);
    #2 chk("oob_sticky", err_oob, 1);
    @(posedge clk); #1;

    // Reset with three entries queued
    alu_valid = 1; alu_addr = 5'd5; alu_data = 64'h11;
    lsu_valid = 1; lsu_addr = 5'd6; lsu_data = 64'h22;
    @(posedge clk); #1;
    alu_data = 64'h33; lsu_data = 64'h44;
    @(posedge clk); #1;
    reset = 1;
    alu_addr = 5'd7; alu_data = 64'h77; lsu_addr = 5'd8; lsu_data = 64'h88;
    #2 chk("mid_rst_alu_ready", alu_ready, 0);
    chk("mid_rst_lsu_ready", lsu_ready, 0);
    @(posedge clk); #3;
    chk("mid_rst_we", wb_we, 0);
    chk("mid_rst_err_clr", err_oob, 0);
    chk("mid_rst_lsu_ready2", lsu_ready, 0);
    @(posedge clk); #1;
    reset = 0; wlog.delete();
    alu_addr = 5'd9; alu_data = 64'h99; lsu_addr = 5'd10; lsu_data = 64'hA0;
    #2 chk("after_rst_we", wb_we, 0);
    @(posedge clk); #1;
    alu_valid = 0; lsu_valid = 0;
    idle(5);
    chk("after_rst_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("after_rst_first_addr", wlog[0].addr, 9);
      chk("after_rst_first_data", wlog[0].data, 64'h99);
      chk("after_rst_second_addr", wlog[1].addr, 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter BIT_NUMBER, default 64, data width of written results.
REQ-002 SHALL have parameter ADDR_NUMBER, default 5, destination address width.
REQ-003 SHALL have parameter REGISTER_NUMBER, default 16, number of architectural registers at the write target.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high; clock clk.
REQ-006 SHALL have ports alu_valid, alu_ready, alu_addr, alu_data  (in, out, in ADDR_NUMBER, in BIT_NUMBER)  ALU result port.
REQ-007 SHALL have ports lsu_valid, lsu_ready, lsu_addr, lsu_data  (in, out, in ADDR_NUMBER, in BIT_NUMBER)  load-store result port.
REQ-008 SHALL have ports wb_we, wb_addr, wb_data  (out 1, out ADDR_NUMBER, out BIT_NUMBER)  registered write port to the register file.
REQ-009 SHALL have port err_oob  output  1  sticky flag: out-of-range destination discarded.
REQ-010 SHALL have ports fwd_valid, fwd_addr, fwd_data  (out 1, out ADDR_NUMBER, out BIT_NUMBER)  bypass port (see Configuration).

Function
REQ-011 SHALL buffer each source in its own 2-entry FIFO; transfer occurs on posedge when valid and ready are both high.
REQ-012 SHALL drive x_ready = 1 iff that source FIFO holds fewer than 2 entries (registered count, no same-cycle pop credit).
REQ-013 SHALL pop at most one entry per cycle from exactly one FIFO and load it into the wb_* output register.
REQ-014 SHALL arbitrate round-robin when both FIFOs are non-empty: grant alternates; pointer advances only on a contested grant.
REQ-015 SHALL grant the sole non-empty FIFO when only one is non-empty, without moving the round-robin pointer.
REQ-016 SHALL give latency 2: entry accepted at edge E drives wb_we=1 in the cycle after edge E+1 when uncontended.
REQ-017 SHALL hold wb_we=1 for exactly one cycle per popped in-range entry; wb_we=0 on idle cycles; wb_addr/wb_data hold last value when idle.
REQ-018 SHALL keep wb_* stable through the whole clock period (changes only at posedge) so a negedge-writing target samples it safely.
REQ-019 SHALL preserve per-source order; same-address writes from both sources in one cycle retire in arbitration order.
REQ-020 SHALL pop an entry with addr >= REGISTER_NUMBER normally but suppress wb_we for it and set err_oob=1.
REQ-021 SHALL sustain one write per cycle under continuous traffic from either or both sources.

Reset
REQ-022 SHALL on reset empty both FIFOs, force wb_we=0, wb_addr=0, wb_data=0, err_oob=0, round-robin pointer to ALU-first.
REQ-023 SHALL discard in-flight entries when reset asserts mid-operation; x_ready=0 during reset cycles, no handshakes accepted.

Configuration
REQ-024 SHALL, with WB_BYPASS_EN defined, drive fwd_valid/fwd_addr/fwd_data as combinational copies of the entry being popped this cycle (in-range only), one cycle ahead of wb_*.
REQ-025 SHALL, without WB_BYPASS_EN, tie fwd_valid, fwd_addr, fwd_data to 0 and synthesize no bypass logic.

Structure
REQ-026 SHALL place default widths, REGISTER_NUMBER and the source-id constants (SRC_ALU=0, SRC_LSU=1) in shared package wb_pkg.
REQ-027 SHALL implement each buffer as sub-module wb_skid_fifo (depth 2, push/pop/full/empty/count), instantiated twice.

Verification
REQ-028 SHALL check single ALU write: alu addr=3 data=0xAA accepted at edge 1 -> wb_we=1, wb_addr=3, wb_data=0xAA after edge 2, for one cycle.
REQ-029 SHALL check contention: both ports valid every cycle, addrs 1/2 -> writes alternate ALU,LSU,ALU,... with wb_we continuously 1.
REQ-030 SHALL check backpressure: LSU valid 4 cycles while ALU saturates -> lsu_ready falls after 2 accepts, no data lost, order kept.
REQ-031 SHALL check out-of-range: alu addr=20 -> no wb_we for it, err_oob=1 and stays set until reset.
REQ-032 SHALL check reset mid-stream with 3 entries queued -> no wb_we after reset, ready=0 during reset, ALU granted first afterwards.
REQ-033 SHALL check WB_BYPASS_EN: fwd_valid=1, fwd_addr=3 one cycle before wb_we for addr=3; without macro fwd_* always 0.
